// File: rtl/apb_core_master.sv
// Per-core APB master: turns one load/store request into an APB SETUP/ACCESS transfer.
// Optional ACCESS timeout guarded by the APB_MASTER_TIMEOUT_EN macro.
module apb_core_master #(
    parameter int BUS_WIDTH      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] ack_rdata,
    output logic                  ack_err,
    output logic [BUS_WIDTH-1:0]  M_PADDR,
    output logic                  M_PWRITE,
    output logic                  M_PSELx,
    output logic                  M_PENABLE,
    output logic [DATA_WIDTH-1:0] M_PWDATA,
    input  logic [DATA_WIDTH-1:0] M_PRDATA,
    input  logic                  M_PREADY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("apb_core_master: TIMEOUT_CYCLES out of range 1..65535");
        end
    endgenerate

    logic [1:0] state;

    assign req_ready = (state == S_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0]           TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(16'hDEAD);

    logic [15:0] tmo_cnt;
    logic        ack_err_r;
    logic        tmo_hit;

    // Abort on the edge that would bring the count of PREADY-less cycles to TIMEOUT_CYCLES.
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign ack_err = ack_err_r;
`else
    assign ack_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            M_PSELx   <= 1'b0;
            M_PENABLE <= 1'b0;
            M_PWRITE  <= 1'b0;
            M_PADDR   <= '0;
            M_PWDATA  <= '0;
            ack       <= 1'b0;
            ack_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
            ack_err_r <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            ack_err_r <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req) begin
                        M_PADDR  <= req_addr;
                        M_PWRITE <= req_we;
                        M_PWDATA <= req_wdata;
                        M_PSELx  <= 1'b1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    M_PENABLE <= 1'b1;
                    state     <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                S_ACCESS: begin
                    // PREADY is checked first so it wins over a simultaneous timeout.
                    if (M_PREADY) begin
                        if (!M_PWRITE) begin
                            ack_rdata <= M_PRDATA;
                        end
                        ack       <= 1'b1;
                        M_PSELx   <= 1'b0;
                        M_PENABLE <= 1'b0;
                        state     <= S_IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        ack_rdata <= ERR_RDATA;
                        ack       <= 1'b1;
                        ack_err_r <= 1'b1;
                        M_PSELx   <= 1'b0;
                        M_PENABLE <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    M_PSELx   <= 1'b0;
                    M_PENABLE <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_core_master.sv
// Directed + randomized bench for apb_core_master; the bench plays both core and APB slave.
module tb_apb_core_master;

    localparam int BW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [BW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          ack;
    logic [DW-1:0] ack_rdata;
    logic          ack_err;
    logic [BW-1:0] M_PADDR;
    logic          M_PWRITE;
    logic          M_PSELx;
    logic          M_PENABLE;
    logic [DW-1:0] M_PWDATA;
    logic [DW-1:0] M_PRDATA = '0;
    logic          M_PREADY = 1'b0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model state: load data the core should currently see on ack_rdata.
    logic [DW-1:0] exp_rdata = '0;

    apb_core_master #(
        .BUS_WIDTH(BW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .ack(ack),
        .ack_rdata(ack_rdata),
        .ack_err(ack_err),
        .M_PADDR(M_PADDR),
        .M_PWRITE(M_PWRITE),
        .M_PSELx(M_PSELx),
        .M_PENABLE(M_PENABLE),
        .M_PWDATA(M_PWDATA),
        .M_PRDATA(M_PRDATA),
        .M_PREADY(M_PREADY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transfer; returns in the ack cycle so a following call is back-to-back.
    task automatic xfer(input logic we, input logic [BW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int waits, input bit poke,
                        output int ack_cyc);
        int t0;
        check("idle_ready", req_ready, 1);
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; M_PREADY = 1'b0;
        tick();
        t0 = cyc;
        req = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
        check("setup_psel", M_PSELx, 1);
        check("setup_penable", M_PENABLE, 0);
        check("setup_paddr", M_PADDR, addr);
        check("setup_pwrite", M_PWRITE, we);
        check("setup_pwdata", M_PWDATA, wd);
        check("setup_ready", req_ready, 0);
        M_PRDATA = rd;
        tick();
        for (int w = 0; w <= waits; w++) begin
            check("access_psel", M_PSELx, 1);
            check("access_penable", M_PENABLE, 1);
            check("access_paddr", M_PADDR, addr);
            check("access_pwdata", M_PWDATA, wd);
            check("access_pwrite", M_PWRITE, we);
            check("access_ack", ack, 0);
            M_PREADY = (w == waits);
            if (poke && w == 0) begin
                req = 1'b1; req_addr = addr ^ 16'h0100;
            end else begin
                req = 1'b0;
            end
            tick();
        end
        req = 1'b0; M_PREADY = 1'b0; M_PRDATA = ~rd;
        if (!we) exp_rdata = rd;
        ack_cyc = cyc;
        check("ack_pulse", ack, 1);
        check("ack_err", ack_err, 0);
        check("ack_rdata", ack_rdata, exp_rdata);
        check("ack_psel", M_PSELx, 0);
        check("ack_penable", M_PENABLE, 0);
        check("ack_ready", req_ready, 1);
        check("latency", cyc - t0, 2 + waits);
    endtask

    initial begin
        int a0, a1;
        logic          r_we;
        logic [BW-1:0] r_addr;
        logic [DW-1:0] r_wd, r_rd;
        int            r_waits;

        // Reset state, applied asynchronously before any clock edge
        #2 reset = 1'b0;
        #1;
        check("rst_psel", M_PSELx, 0);
        check("rst_penable", M_PENABLE, 0);
        check("rst_pwrite", M_PWRITE, 0);
        check("rst_paddr", M_PADDR, 0);
        check("rst_pwdata", M_PWDATA, 0);
        check("rst_ack", ack, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_ack_rdata", ack_rdata, 0);
        check("rst_ready", req_ready, 1);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Read, zero wait states
        xfer(1'b0, 16'h0030, 16'h0000, 16'h1234, 0, 1'b0, a0);
        tick();
        check("ack_one_cycle", ack, 0);

        // Write, three wait states; ack_rdata must keep the earlier load data
        xfer(1'b1, 16'h0045, 16'hBEEF, 16'h5555, 3, 1'b0, a0);
        tick();

        // Back-to-back: second request presented in the ack cycle of the first
        xfer(1'b0, 16'h0010, 16'h0000, 16'hA5A5, 0, 1'b0, a0);
        xfer(1'b1, 16'h0020, 16'hC3C3, 16'h0F0F, 0, 1'b0, a1);
        check("b2b_spacing", a1 - a0, 3);
        tick();

        // Request pulsed during ACCESS is ignored
        xfer(1'b0, 16'h0077, 16'h0000, 16'h7E57, 2, 1'b1, a0);
        tick();
        check("ignored_ack", ack, 0);
        check("ignored_psel", M_PSELx, 0);
        check("ignored_ready", req_ready, 1);
        tick();
        check("ignored_psel2", M_PSELx, 0);

`ifndef APB_MASTER_TIMEOUT_EN
        // Without timeout, a long wait still completes normally
        xfer(1'b0, 16'h0099, 16'h0000, 16'h4242, 7, 1'b0, a0);
        tick();
`endif

        // Async reset in the middle of ACCESS
        req = 1'b1; req_we = 1'b0; req_addr = 16'h0055;
        tick();
        req = 1'b0;
        tick();
        check("pre_rst_penable", M_PENABLE, 1);
        #3 reset = 1'b0;
        #1;
        check("midrst_psel", M_PSELx, 0);
        check("midrst_penable", M_PENABLE, 0);
        check("midrst_ack", ack, 0);
        check("midrst_paddr", M_PADDR, 0);
        check("midrst_rdata", ack_rdata, 0);
        exp_rdata = '0;
        M_PREADY = 1'b1;
        tick(); tick();
        check("inrst_ack", ack, 0);
        check("inrst_ready", req_ready, 1);
        M_PREADY = 1'b0;
        reset = 1'b1;
        tick();
        check("postrst_ready", req_ready, 1);
        check("postrst_psel", M_PSELx, 0);
        xfer(1'b0, 16'h0030, 16'h0000, 16'h8001, 0, 1'b0, a0);
        tick();

`ifdef APB_MASTER_TIMEOUT_EN
        // Timeout: PREADY never arrives
        req = 1'b1; req_we = 1'b0; req_addr = 16'h00E0; M_PRDATA = 16'h1111;
        tick();
        req = 1'b0;
        tick();
        for (int w = 0; w < TMO; w++) begin
            check("tmo_penable", M_PENABLE, 1);
            check("tmo_ack_low", ack, 0);
            tick();
        end
        exp_rdata = 16'hDEAD;
        check("tmo_ack", ack, 1);
        check("tmo_ack_err", ack_err, 1);
        check("tmo_rdata", ack_rdata, exp_rdata);
        check("tmo_psel", M_PSELx, 0);
        check("tmo_penable_off", M_PENABLE, 0);
        check("tmo_ready", req_ready, 1);
        tick();
        check("tmo_err_clear", ack_err, 0);
        // PREADY on the last tolerated cycle wins over the timeout
        xfer(1'b0, 16'h00E4, 16'h0000, 16'h2222, TMO - 1, 1'b0, a0);
        tick();
`endif

        // Randomized transfers against the model
        for (int i = 0; i < 10; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 16'($urandom);
            r_wd    = 16'($urandom);
            r_rd    = 16'($urandom);
            r_waits = int'($urandom_range(0, TMO - 1));
            xfer(r_we, r_addr, r_wd, r_rd, r_waits, 1'b0, a0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        check("final_ack", ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
